mc_controller: RTL
==================

// Module: mc_controller
// PURPOSE
//  Multicycle control unit for the ARM core: sequences one shared ALU, register file and unified memory
//  over 3-5 cycles per instruction. Owns the main FSM, the NZCV flags register and conditional-execution
//  gating. Emits every mux select and write enable for the datapath; holds no data path state itself.
// PARAMETERS
//  RESET_FLAGS  4'b0000  NZCV value loaded into the flags register on reset
// PORTS
//  clk         in   1   core clock, all state on rising edge
//  reset       in   1   synchronous, active-high; forces FSM to FETCH and flags to RESET_FLAGS
//  Cond        in   4   Instr[31:28]
//  Op          in   2   Instr[27:26]: 00 data-proc, 01 LDR/STR, 10 branch, 11 undefined
//  Funct       in   6   Instr[25:20]: [5]=I (immediate), [4:1]=cmd, [0]=S (data-proc) / L (mem)
//  Rd          in   4   Instr[15:12]
//  ShType      in   2   Instr[6:5], register shift type
//  ALUFlags    in   4   NZCV from ALU, current cycle
//  PCWrite, MemWrite, RegWrite, IRWrite  out 1  write enables
//  AdrSrc      out  1   0=PC, 1=ALU result register as memory address
//  ResultSrc   out  2   00 ALUOut reg, 01 memory data reg, 10 raw ALUResult
//  ALUSrcA     out  1   0=RD1 reg, 1=PC
//  ALUSrcB     out  2   00 RD2 reg, 01 ExtImm, 10 constant 4
//  ImmSrc      out  2   = Op
//  RegSrc      out  2   [0]=(Op==10) RA1<-R15; [1]=(Op==01) RA2<-Rd
//  ALUControl  out  4   0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 EOR, 0101 pass-B
//  RegControl  out  2   = ShType in EXECR, else 00
//  FlagsQ      out  4   current flags register (debug/trace)
// BEHAVIOUR
//  States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH. Reset state FETCH.
//  Transitions: FETCH->DECODE. DECODE: Op01->MEMADR; Op00&!I->EXECR; Op00&I->EXECI; Op10->BRANCH;
//   Op11->FETCH (NOP). MEMADR: L->MEMRD else MEMWR. MEMRD->MEMWB->FETCH. MEMWR->FETCH.
//   EXECR/EXECI->ALUWB->FETCH. BRANCH->FETCH. Unconditional: a failed condition does not shorten a path.
//  Per-state outputs (unlisted = 0, ALUControl default ADD):
//   FETCH  AdrSrc0 IRWrite1 ALUSrcA1 ALUSrcB10 ResultSrc10 PCWrite1
//   DECODE ALUSrcA1 ALUSrcB10 ResultSrc10 (PC+8 for R15 reads)
//   MEMADR ALUSrcA0 ALUSrcB01 ADD | MEMRD AdrSrc1 | MEMWR AdrSrc1 MemWrite=CondEx
//   MEMWB  ResultSrc01 RegWrite=CondEx; PCWrite=CondEx&(Rd==15)
//   EXECR  ALUSrcB00 decoded op | EXECI ALUSrcB01 decoded op
//   ALUWB  ResultSrc00 RegWrite=CondEx&WB; PCWrite=CondEx&WB&(Rd==15)
//   BRANCH ALUSrcA0 ALUSrcB01 ResultSrc10 ADD PCWrite=CondEx
//  cmd decode: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1101 MOV(pass-B) -> WB=1;
//   1010 CMP(SUB), 1000 TST(AND) -> WB=0, flags written regardless of S; any other cmd -> NOP (WB=0, no flags).
//  CondEx: evaluated from FlagsQ in DECODE and latched into condex_q; used by all later states of that
//   instruction (flags updated in EXEC must not alter it). Codes 0000-1101 per ARM (EQ..LE), 1110 AL=1, 1111=0.
//  Flags register: in EXECR/EXECI, if CondEx & (S | CMP | TST) & cmd supported, FlagsQ<=ALUFlags at edge.
//  Reset: while reset=1 all write enables (PCWrite, MemWrite, RegWrite, IRWrite) forced 0; FSM held in FETCH;
//   FlagsQ=RESET_FLAGS, condex_q=0. Reset mid-instruction abandons it; first edge after release is a FETCH.
//  Latency (cycles incl. FETCH): branch 3, data-proc 4, STR 4, LDR 5, undefined 2.
// TESTING
//  Reset 2 cycles, release -> cycle 1 FETCH: PCWrite=1 IRWrite=1 ALUSrcB=10; all enables 0 during reset.
//  ADD R1 (Op00 I0 cmd0100 S1, Cond1110), ALUFlags=0100 in EXECR -> 4 cycles, RegWrite=1 in ALUWB, FlagsQ=0100.
//  CMP then BEQ (Cond0000): ALUFlags=0100 on CMP -> RegWrite=0 in ALUWB; BRANCH PCWrite=1; with Z=0 -> PCWrite=0.
//  LDR Rd=15 Cond1110 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; MEMWB ResultSrc=01 RegWrite=1 PCWrite=1.
//  ADDSNE with Z=1 -> EXECR flags unchanged, ALUWB RegWrite=0; condex_q stays 0 though EXEC had new flags.
//  Assert reset in MEMWR of STR -> MemWrite=0 that cycle; next post-reset state FETCH, FlagsQ=RESET_FLAGS.

Source files
------------

// File: rtl/mc_controller.sv
// mc_controller: multicycle control unit for the ARM core.
// It sequences one shared ALU, register file and unified memory over 3-5 cycles
// per instruction. It owns the main FSM, the NZCV flags register and the
// conditional-execution gating, and it drives every datapath mux select and
// write enable. It holds no datapath state.
//
// Ports
//   clk, reset            core clock; synchronous active-high reset
//   Cond/Op/Funct/Rd      instruction fields from the instruction register
//   ShType                register shift type, passed out as RegControl in EXECR
//   ALUFlags              NZCV produced by the ALU in the current cycle
//   PCWrite, MemWrite,
//   RegWrite, IRWrite     write enables (all held at 0 while reset is high)
//   AdrSrc, ResultSrc,
//   ALUSrcA, ALUSrcB,
//   ImmSrc, RegSrc,
//   ALUControl,
//   RegControl            datapath selects
//   FlagsQ                current flags register {N,Z,C,V}
//   fsm_state             current FSM state encoding, for trace and checkers
//
// There is no valid/ready handshake on this block. Instruction fields are
// assumed stable from DECODE until the instruction returns to FETCH.
module mc_controller #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [1:0] ShType,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] ALUControl,
  output logic [1:0] RegControl,
  output logic [3:0] FlagsQ,
  output logic [3:0] fsm_state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_ORR  = 4'b0011;
  localparam logic [3:0] ALU_EOR  = 4'b0100;
  localparam logic [3:0] ALU_PASS = 4'b0101;

  state_t     state_q, state_d;
  logic [3:0] flags_q;
  logic       condex_q;

  logic [3:0] cmd;
  logic       i_bit, s_bit;
  logic [3:0] dec_alu;
  logic       dec_wb;
  logic       dec_ok;    // command is supported
  logic       dec_test;  // CMP/TST: flags written regardless of S
  logic       cond_ok;
  logic       flag_we;
  logic       n_f, z_f, c_f, v_f;

  assign cmd   = Funct[4:1];
  assign i_bit = Funct[5];
  assign s_bit = Funct[0];

  assign FlagsQ    = flags_q;
  assign fsm_state = state_q;
  assign ImmSrc    = Op;
  assign RegSrc    = {(Op == 2'b01), (Op == 2'b10)};

  // Data-processing command decode
  always_comb begin
    dec_alu  = ALU_ADD;
    dec_wb   = 1'b0;
    dec_ok   = 1'b1;
    dec_test = 1'b0;
    case (cmd)
      4'b0100: begin dec_alu = ALU_ADD;  dec_wb = 1'b1; end
      4'b0010: begin dec_alu = ALU_SUB;  dec_wb = 1'b1; end
      4'b0000: begin dec_alu = ALU_AND;  dec_wb = 1'b1; end
      4'b1100: begin dec_alu = ALU_ORR;  dec_wb = 1'b1; end
      4'b0001: begin dec_alu = ALU_EOR;  dec_wb = 1'b1; end
      4'b1101: begin dec_alu = ALU_PASS; dec_wb = 1'b1; end
      4'b1010: begin dec_alu = ALU_SUB;  dec_test = 1'b1; end
      4'b1000: begin dec_alu = ALU_AND;  dec_test = 1'b1; end
      default: dec_ok = 1'b0;
    endcase
  end

  // Condition evaluation against the flags held at DECODE time
  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_ok = 1'b0;
    case (Cond)
      4'b0000: cond_ok = z_f;
      4'b0001: cond_ok = !z_f;
      4'b0010: cond_ok = c_f;
      4'b0011: cond_ok = !c_f;
      4'b0100: cond_ok = n_f;
      4'b0101: cond_ok = !n_f;
      4'b0110: cond_ok = v_f;
      4'b0111: cond_ok = !v_f;
      4'b1000: cond_ok = c_f && !z_f;
      4'b1001: cond_ok = !c_f || z_f;
      4'b1010: cond_ok = (n_f == v_f);
      4'b1011: cond_ok = (n_f != v_f);
      4'b1100: cond_ok = !z_f && (n_f == v_f);
      4'b1101: cond_ok = z_f || (n_f != v_f);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // The latched condition, not the live flags, gates the flag update so an
  // instruction cannot re-qualify itself with flags it produces.
  assign flag_we = ((state_q == S_EXECR) || (state_q == S_EXECI)) &&
                   condex_q && dec_ok && (s_bit || dec_test);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      flags_q  <= RESET_FLAGS;
      condex_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) condex_q <= cond_ok;
      if (flag_we)             flags_q  <= ALUFlags;
    end
  end

  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    RegControl = 2'b00;
    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // PC+4 again, so R15 reads see PC+8
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = i_bit ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = condex_q;
        PCWrite   = condex_q && (Rd == 4'd15);
        state_d   = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = condex_q;
        state_d  = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcB    = 2'b00;
        ALUControl = dec_alu;
        RegControl = ShType;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = dec_alu;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc = 2'b00;
        RegWrite  = condex_q && dec_wb;
        PCWrite   = condex_q && dec_wb && (Rd == 4'd15);
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = condex_q;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      IRWrite  = 1'b0;
    end
  end

endmodule
